// File: rtl/discharge_pulse_ctrl.sv
// EDM discharge-pulse sequencer: gates the pulse MOSFET, times WAIT/DISCHARGE/DEION,
// handles open-circuit timeout and short detection, and keeps saturating event counters.
`timescale 1ns/1ps
module discharge_pulse_ctrl #(
    parameter logic signed [15:0] SHORT_THRESHOLD_VOL = 16'sd8,
    parameter logic [15:0]        SHORT_DETECT_TIME   = 16'd50,
    parameter logic [15:0]        SHORT_PAUSE_CYCLES  = 16'd2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               machine_start,
    input  logic [15:0]        ton_cycles,
    input  logic [15:0]        toff_cycles,
    input  logic [15:0]        wait_timeout,
    input  logic signed [15:0] sample_voltage,
    input  logic               is_breakdown,
    input  logic               counter_clear,
    output logic [7:0]         current_state,
    output logic               gate_on,
    output logic               pulse_done,
    output logic               open_evt,
    output logic               short_evt,
    output logic [15:0]        discharge_count,
    output logic [15:0]        open_count,
    output logic [15:0]        short_count
);

    localparam logic [7:0] S_IDLE        = 8'b1000_0000;
    localparam logic [7:0] S_WAIT        = 8'b0000_0001;
    localparam logic [7:0] S_DISCHARGE   = 8'b0000_0010;
    localparam logic [7:0] S_DEION       = 8'b0000_0100;
    localparam logic [7:0] S_SHORT_PAUSE = 8'b0000_1000;

    logic [7:0]  r_state;
    logic [15:0] r_timer;
    logic [15:0] r_short_cnt;
    logic [15:0] r_ton;
    logic [15:0] r_toff;
    logic [15:0] r_timeout;
    logic        r_gate_on;
    logic        r_pulse_done;
    logic        r_open_evt;
    logic        r_short_evt;
    logic [15:0] r_discharge_count;
    logic [15:0] r_open_count;
    logic [15:0] r_short_count;

    logic [7:0]  w_next_state;
    logic        w_pulse;
    logic        w_open;
    logic        w_short;
    logic        w_low;
    logic        w_short_hit;
    logic [15:0] w_short_next;
    logic        w_enter_wait;

    // Event strobes are valid for exactly one cycle with no back-pressure; the matching
    // counter already holds the updated value in that same cycle.
    assign w_low        = sample_voltage < SHORT_THRESHOLD_VOL;
    assign w_short_next = w_low ? (r_short_cnt + 16'd1) : 16'd0;
    assign w_short_hit  = w_low && (r_short_cnt == (SHORT_DETECT_TIME - 16'd1));
    assign w_enter_wait = (w_next_state == S_WAIT) && (r_state != S_WAIT);

    always_comb begin
        w_next_state = r_state;
        w_pulse      = 1'b0;
        w_open       = 1'b0;
        w_short      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (machine_start) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (!machine_start) begin
                    w_next_state = S_DEION;
                end else if (is_breakdown) begin
                    w_next_state = S_DISCHARGE;
                end else if (w_short_hit) begin
                    w_next_state = S_SHORT_PAUSE;
                    w_short      = 1'b1;
                end else if (r_timer == (r_timeout - 16'd1)) begin
                    w_next_state = S_DEION;
                    w_open       = 1'b1;
                end
            end
            S_DISCHARGE: begin
                if (r_timer == (r_ton - 16'd1)) begin
                    w_next_state = S_DEION;
                    w_pulse      = 1'b1;
                end
            end
            S_DEION: begin
                if (r_timer == (r_toff - 16'd1))
                    w_next_state = machine_start ? S_WAIT : S_IDLE;
            end
            S_SHORT_PAUSE: begin
                if (r_timer == (SHORT_PAUSE_CYCLES - 16'd1))
                    w_next_state = machine_start ? S_WAIT : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gate_on    <= 1'b0;
            r_timer      <= 16'd0;
            r_short_cnt  <= 16'd0;
            r_ton        <= 16'd1;
            r_toff       <= 16'd1;
            r_timeout    <= 16'd1;
            r_pulse_done <= 1'b0;
            r_open_evt   <= 1'b0;
            r_short_evt  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_gate_on    <= (w_next_state == S_WAIT) || (w_next_state == S_DISCHARGE);
            r_pulse_done <= w_pulse;
            r_open_evt   <= w_open;
            r_short_evt  <= w_short;
            // Timer restarts at 0 on every state change and idles at 0.
            if ((w_next_state != r_state) || (r_state == S_IDLE))
                r_timer <= 16'd0;
            else
                r_timer <= r_timer + 16'd1;
            if ((r_state == S_WAIT) && (w_next_state == S_WAIT))
                r_short_cnt <= w_short_next;
            else
                r_short_cnt <= 16'd0;
            // Zero-valued settings are clamped to one cycle so the timers always terminate.
            if (w_enter_wait) begin
                r_ton     <= (ton_cycles   == 16'd0) ? 16'd1 : ton_cycles;
                r_toff    <= (toff_cycles  == 16'd0) ? 16'd1 : toff_cycles;
                r_timeout <= (wait_timeout == 16'd0) ? 16'd1 : wait_timeout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_discharge_count <= 16'd0;
            r_open_count      <= 16'd0;
            r_short_count     <= 16'd0;
        end else if (counter_clear) begin
            r_discharge_count <= 16'd0;
            r_open_count      <= 16'd0;
            r_short_count     <= 16'd0;
        end else begin
            if (w_pulse && (r_discharge_count != 16'hFFFF)) r_discharge_count <= r_discharge_count + 16'd1;
            if (w_open  && (r_open_count      != 16'hFFFF)) r_open_count      <= r_open_count + 16'd1;
            if (w_short && (r_short_count     != 16'hFFFF)) r_short_count     <= r_short_count + 16'd1;
        end
    end

    assign current_state   = r_state;
    assign gate_on         = r_gate_on;
    assign pulse_done      = r_pulse_done;
    assign open_evt        = r_open_evt;
    assign short_evt       = r_short_evt;
    assign discharge_count = r_discharge_count;
    assign open_count      = r_open_count;
    assign short_count     = r_short_count;

endmodule

// File: tb/tb_discharge_pulse_ctrl.sv
// Bench for discharge_pulse_ctrl: directed pulse cycles with an event scoreboard
// (state, strobe kind, counter) checked by an independent monitor.
`timescale 1ns/1ps
module tb_discharge_pulse_ctrl;

    localparam logic [7:0] ST_IDLE  = 8'b1000_0000;
    localparam logic [7:0] ST_WAIT  = 8'b0000_0001;
    localparam logic [7:0] ST_DIS   = 8'b0000_0010;
    localparam logic [7:0] ST_DEION = 8'b0000_0100;
    localparam logic [7:0] ST_SP    = 8'b0000_1000;
    localparam logic [2:0] K_PULSE  = 3'b001;
    localparam logic [2:0] K_OPEN   = 3'b010;
    localparam logic [2:0] K_SHORT  = 3'b100;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               machine_start;
    logic [15:0]        ton_cycles;
    logic [15:0]        toff_cycles;
    logic [15:0]        wait_timeout;
    logic signed [15:0] sample_voltage;
    logic               is_breakdown;
    logic               counter_clear;
    logic [7:0]         current_state;
    logic               gate_on;
    logic               pulse_done;
    logic               open_evt;
    logic               short_evt;
    logic [15:0]        discharge_count;
    logic [15:0]        open_count;
    logic [15:0]        short_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [26:0] exp_q[$];
    logic [26:0] mon_act;
    logic [26:0] mon_exp;
    logic [15:0] mon_cnt;

    discharge_pulse_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .machine_start   (machine_start),
        .ton_cycles      (ton_cycles),
        .toff_cycles     (toff_cycles),
        .wait_timeout    (wait_timeout),
        .sample_voltage  (sample_voltage),
        .is_breakdown    (is_breakdown),
        .counter_clear   (counter_clear),
        .current_state   (current_state),
        .gate_on         (gate_on),
        .pulse_done      (pulse_done),
        .open_evt        (open_evt),
        .short_evt       (short_evt),
        .discharge_count (discharge_count),
        .open_count      (open_count),
        .short_count     (short_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [26:0] ev(input logic [7:0] st, input logic [2:0] kind, input logic [15:0] cnt);
        return {st, kind, cnt};
    endfunction

    // Called at a negedge; counts cycles spent in st and gate-on cycles among them.
    task automatic run_state(input logic [7:0] st, output int n, output int g);
        n = 0;
        g = 0;
        while (current_state == st && n < 5000) begin
            n++;
            if (gate_on) g++;
            @(negedge clk);
        end
        if (n >= 5000) check("run_state_bound", 32'(n), 32'd0);
    endtask

    // monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin
        if (rst_n && (pulse_done || open_evt || short_evt)) begin
            mon_cnt = pulse_done ? discharge_count : (open_evt ? open_count : short_count);
            mon_act = {current_state, short_evt, open_evt, pulse_done, mon_cnt};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got %0h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    int n, g, gd;

    initial begin
        rst_n = 1'b0; machine_start = 1'b0; ton_cycles = 16'd100; toff_cycles = 16'd200;
        wait_timeout = 16'd1000; sample_voltage = 16'sd80; is_breakdown = 1'b0; counter_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", 32'(current_state), 32'(ST_IDLE));
        check("reset_gate", 32'(gate_on), 32'd0);
        check("reset_counts", {discharge_count, open_count | short_count}, 32'd0);

        // breakdown at WAIT cycle 20
        machine_start = 1'b1;
        @(negedge clk);
        check("t1_wait", 32'(current_state), 32'(ST_WAIT));
        g = 0;
        for (int i = 0; i < 20; i++) begin
            if (gate_on) g++;
            @(negedge clk);
        end
        if (gate_on) g++;
        is_breakdown = 1'b1;
        exp_q.push_back(ev(ST_DEION, K_PULSE, 16'd1));
        @(negedge clk);
        is_breakdown = 1'b0;
        check("t1_discharge", 32'(current_state), 32'(ST_DIS));
        run_state(ST_DIS, n, gd);
        check("t1_ton_len", 32'(n), 32'd100);
        check("t1_gate_len", 32'(g + gd), 32'd121);
        run_state(ST_DEION, n, gd);
        check("t1_toff_len", 32'(n), 32'd200);
        check("t1_deion_gate", 32'(gd), 32'd0);
        check("t1_back_wait", 32'(current_state), 32'(ST_WAIT));

        // open-circuit timeout
        exp_q.push_back(ev(ST_DEION, K_OPEN, 16'd1));
        run_state(ST_WAIT, n, g);
        check("t2_wait_len", 32'(n), 32'd1000);
        check("t2_wait_gate", 32'(g), 32'd1000);
        run_state(ST_DEION, n, gd);
        check("t2_toff_len", 32'(n), 32'd200);

        // short with a restart at cycle 30
        sample_voltage = 16'sd2;
        repeat (30) @(negedge clk);
        sample_voltage = 16'sd9;
        @(negedge clk);
        sample_voltage = 16'sd2;
        exp_q.push_back(ev(ST_SP, K_SHORT, 16'd1));
        run_state(ST_WAIT, n, g);
        check("t3_wait_after_restart", 32'(n), 32'd50);
        sample_voltage = 16'sd80;
        run_state(ST_SP, n, gd);
        check("t3_pause_len", 32'(n), 32'd2000);
        check("t3_pause_gate", 32'(gd), 32'd0);
        check("t3_back_wait", 32'(current_state), 32'(ST_WAIT));

        // breakdown coincides with the 50th low sample
        sample_voltage = 16'sd2;
        repeat (49) @(negedge clk);
        is_breakdown = 1'b1;
        exp_q.push_back(ev(ST_DEION, K_PULSE, 16'd2));
        @(negedge clk);
        is_breakdown = 1'b0;
        sample_voltage = 16'sd80;
        check("t4_breakdown_wins", 32'(current_state), 32'(ST_DIS));
        run_state(ST_DIS, n, gd);
        run_state(ST_DEION, n, gd);

        // machine_start drop in WAIT
        machine_start = 1'b0;
        @(negedge clk);
        check("t5_drop_deion", 32'(current_state), 32'(ST_DEION));
        run_state(ST_DEION, n, gd);
        check("t5_toff_len", 32'(n), 32'd200);
        check("t5_idle", 32'(current_state), 32'(ST_IDLE));
        check("t5_counts", {discharge_count, open_count}, {16'd2, 16'd1});
        check("t5_short_count", 32'(short_count), 32'd1);

        // machine_start drop in DISCHARGE
        ton_cycles = 16'd5; toff_cycles = 16'd7;
        machine_start = 1'b1;
        @(negedge clk);
        is_breakdown = 1'b1;
        exp_q.push_back(ev(ST_DEION, K_PULSE, 16'd3));
        @(negedge clk);
        is_breakdown = 1'b0;
        machine_start = 1'b0;
        run_state(ST_DIS, n, gd);
        check("t6_ton_len", 32'(n), 32'd5);
        run_state(ST_DEION, n, gd);
        check("t6_toff_len", 32'(n), 32'd7);
        check("t6_idle", 32'(current_state), 32'(ST_IDLE));

        // zero settings act as one cycle
        ton_cycles = 16'd0; toff_cycles = 16'd0; wait_timeout = 16'd0;
        machine_start = 1'b1;
        @(negedge clk);
        exp_q.push_back(ev(ST_DEION, K_OPEN, 16'd2));
        run_state(ST_WAIT, n, g);
        check("t7_wait_len", 32'(n), 32'd1);
        run_state(ST_DEION, n, gd);
        check("t7_toff_len", 32'(n), 32'd1);
        is_breakdown = 1'b1;
        exp_q.push_back(ev(ST_DEION, K_PULSE, 16'd4));
        @(negedge clk);
        is_breakdown = 1'b0;
        run_state(ST_DIS, n, gd);
        check("t7_ton_len", 32'(n), 32'd1);
        run_state(ST_DEION, n, gd);
        machine_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t7_idle", 32'(current_state), 32'(ST_IDLE));

        // saturation from a preloaded counter
        force dut.r_discharge_count = 16'hFFFF;
        #1;
        release dut.r_discharge_count;
        machine_start = 1'b1;
        @(negedge clk);
        is_breakdown = 1'b1;
        @(negedge clk);
        is_breakdown = 1'b0;
        machine_start = 1'b0;
        exp_q.push_back(ev(ST_DEION, K_PULSE, 16'hFFFF));
        @(negedge clk);
        @(negedge clk);
        check("t8_saturated", 32'(discharge_count), 32'hFFFF);

        // clear concurrent with pulse_done
        machine_start = 1'b1;
        @(negedge clk);
        is_breakdown = 1'b1;
        @(negedge clk);
        is_breakdown = 1'b0;
        machine_start = 1'b0;
        counter_clear = 1'b1;
        exp_q.push_back(ev(ST_DEION, K_PULSE, 16'd0));
        @(negedge clk);
        counter_clear = 1'b0;
        check("t9_cleared", {open_count, short_count}, 32'd0);
        @(negedge clk);

        // asynchronous reset mid-DISCHARGE
        ton_cycles = 16'd100;
        machine_start = 1'b1;
        @(negedge clk);
        exp_q.push_back(ev(ST_DEION, K_OPEN, 16'd1));
        run_state(ST_WAIT, n, g);
        run_state(ST_DEION, n, gd);
        is_breakdown = 1'b1;
        @(negedge clk);
        is_breakdown = 1'b0;
        check("t10_discharge", 32'(current_state), 32'(ST_DIS));
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t10_rst_gate", 32'(gate_on), 32'd0);
        check("t10_rst_state", 32'(current_state), 32'(ST_IDLE));
        check("t10_rst_counts", {discharge_count, open_count}, 32'd0);
        machine_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/discharge_pulse_ctrl.md
# discharge_pulse_ctrl

EDM discharge-pulse sequencer: drives the one-hot discharge state bus consumed by the breakdown detector, gates the pulse MOSFET, and times each pulse cycle (wait-for-breakdown, on-time, deionization off-time). It handles open-circuit timeout and short-circuit detection with a recovery pause, and keeps saturating event counters for the servo/host. It sits between the host/servo configuration registers and the breakdown detector/gate driver.

## Interface
- SHORT_THRESHOLD_VOL, 16'sd8, signed gap voltage (V) below which a WAIT cycle counts as short
- SHORT_DETECT_TIME, 16'd50, consecutive short cycles in WAIT that declare a short (must be ≥1)
- SHORT_PAUSE_CYCLES, 16'd2000, gate-off recovery time after a short (must be ≥1)
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  reset, asynchronous, active-low
- machine_start  in  1  level enable; high = keep generating pulses
- ton_cycles  in  16  discharge on-time in clk cycles (0 treated as 1)
- toff_cycles  in  16  deionization off-time in clk cycles (0 treated as 1)
- wait_timeout  in  16  max WAIT duration before open-circuit (0 treated as 1)
- sample_voltage  in  16 signed  gap voltage (V)
- is_breakdown  in  1  breakdown flag from detector (registered, valid only in WAIT)
- counter_clear  in  1  synchronous clear of all event counters
- current_state  out  8  one-hot state: IDLE 8'b10000000, WAIT 8'b00000001, DISCHARGE 8'b00000010, DEION 8'b00000100, SHORT_PAUSE 8'b00001000
- gate_on  out  1  MOSFET gate drive
- pulse_done  out  1  one-cycle strobe per completed discharge
- open_evt  out  1  one-cycle strobe per open-circuit timeout
- short_evt  out  1  one-cycle strobe per detected short
- discharge_count, open_count, short_count  out  16 each  saturating event counters

## Operation
- Reset: current_state=IDLE, gate_on=0, all strobes 0, all counters 0, internal timers 0, latched config = 1.
- Config (ton, toff, timeout, zero→1) latched on every transition into WAIT; held constant for that pulse cycle.
- IDLE: machine_start=1 → WAIT.
- WAIT (timer counts 0,1,… from entry). Priority: (1) machine_start=0 → DEION, no counter/strobe; (2) is_breakdown=1 → DISCHARGE; (3) short counter reaches SHORT_DETECT_TIME → SHORT_PAUSE, short_evt, short_count++; (4) timer = timeout−1 → DEION, open_evt, open_count++.
- Short counter: in WAIT increments when sample_voltage < SHORT_THRESHOLD_VOL (signed compare), else resets to 0; reset to 0 outside WAIT.
- DISCHARGE: lasts exactly ton cycles regardless of machine_start, then → DEION with pulse_done, discharge_count++.
- DEION: lasts exactly toff cycles, then → WAIT if machine_start=1, else IDLE.
- SHORT_PAUSE: lasts SHORT_PAUSE_CYCLES, then → WAIT if machine_start=1, else IDLE.
- gate_on=1 exactly when current_state ∈ {WAIT, DISCHARGE}; registered together with the state, never glitches.
- Counters saturate at 16'hFFFF; counter_clear=1 zeroes them, and clear wins over a same-cycle increment (result 0).

## Timing
- All outputs registered; state, gate_on, strobes and counter updates change on the same clk edge.
- is_breakdown sampled high in WAIT cycle n → current_state=DISCHARGE and gate_on=1 from cycle n+1 (gate stays on across WAIT→DISCHARGE).
- Strobes are high for exactly the first cycle of the destination state (DEION or SHORT_PAUSE); counter reflects the increment in that same cycle.
- WAIT with no event occupies exactly timeout cycles; the short is declared on the cycle the SHORT_DETECT_TIME-th consecutive low sample is seen, taking effect the next edge.
- Minimum pulse period (ton=toff=1, immediate breakdown): WAIT ≥1 + DISCHARGE 1 + DEION 1 cycles.
- Mid-operation reset: immediate return to reset values, gate_on=0 asynchronously.

## Test plan
- Start with ton=100, toff=200, timeout=1000, force is_breakdown high at WAIT cycle 20 → DISCHARGE 100 cycles, gate_on high 121 cycles, pulse_done once, discharge_count=1, DEION 200 cycles, back to WAIT.
- No breakdown, voltage 80 V, timeout=1000 → WAIT exactly 1000 cycles, open_evt once, open_count=1, gate_on drops, DEION toff cycles.
- Voltage 2 V in WAIT → short_evt after 50 consecutive low cycles, SHORT_PAUSE 2000 cycles gate off, short_count=1; a single 9 V sample at cycle 30 restarts the count.
- is_breakdown and short threshold reached in same cycle → DISCHARGE wins, no short_evt; machine_start drop in WAIT → DEION, no counters change; drop in DISCHARGE → full ton, then IDLE after toff.
- ton=toff=timeout=0 → each treated as 1 cycle; preload counters to 16'hFFFF → stays 16'hFFFF; counter_clear concurrent with pulse_done → count 0.
- Assert rst_n low mid-DISCHARGE → gate_on=0 immediately, IDLE, counters 0.
